// File: rtl/comma_align.sv
// Receive-side 10-bit comma aligner and byte-sync FSM feeding the 8b/10b decoder.
// Searches a 20-bit window for K28.x commas, barrel-shifts to word boundaries, tracks lock.
module comma_align #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_MAX  = 4,
  parameter int unsigned GOOD_RUN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_in,
  input  logic       rx_vld,
  input  logic       realign_en,
  input  logic       err_in,
  output logic [9:0] data_out,
  output logic       data_vld,
  output logic       comma_det,
  output logic [3:0] align_pos,
  output logic       byte_lock
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] ERR_C  = 4'(ERR_MAX);
  localparam logic [7:0] GOOD_C = 8'(GOOD_RUN);

  typedef enum logic [1:0] {LOSS, ACQ, SYNC} state_t;

  state_t      state, state_n;
  logic [9:0]  prev;
  logic [3:0]  ccnt, ccnt_n;
  logic [3:0]  bcnt, bcnt_n;
  logic [7:0]  gcnt, gcnt_n;

  logic [19:0] win;
  logic        hit;
  logic [3:0]  k_hit;
  logic [3:0]  new_pos;
  logic [9:0]  aligned;
  logic        good_c, mis_c, bad_e;

  assign win = {rx_in, prev};

  // Scan upward and keep the first match so the lowest offset wins.
  always_comb begin
    hit   = 1'b0;
    k_hit = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (!hit && (win[k +: 7] == 7'b1111100 || win[k +: 7] == 7'b0000011)) begin
        hit   = 1'b1;
        k_hit = 4'(k);
      end
    end
  end

  assign new_pos = (hit && realign_en && state != SYNC) ? k_hit : align_pos;
  assign aligned = win[new_pos +: 10];
  assign good_c  = rx_vld && hit && (k_hit == new_pos);
  assign mis_c   = rx_vld && hit && (k_hit != align_pos);
  // The error flag describes the word already on data_out, so it is not gated by rx_vld.
  assign bad_e   = data_vld && err_in;

  always_comb begin
    state_n = state;
    ccnt_n  = ccnt;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    unique case (state)
      LOSS: begin
        if (good_c) begin
          state_n = ACQ;
          ccnt_n  = 4'd1;
        end
      end
      ACQ: begin
        if (bad_e) begin
          state_n = LOSS;
          ccnt_n  = '0;
        end else if (mis_c && realign_en) begin
          ccnt_n = 4'd1;
        end else if (good_c) begin
          if (ccnt >= LOCK_C - 4'd1) begin
            state_n = SYNC;
            ccnt_n  = LOCK_C;
            bcnt_n  = '0;
            gcnt_n  = '0;
          end else begin
            ccnt_n = ccnt + 4'd1;
          end
        end
      end
      SYNC: begin
        if (bad_e || mis_c) begin
          gcnt_n = '0;
          if (bcnt >= ERR_C - 4'd1) begin
            state_n = LOSS;
            bcnt_n  = ERR_C;
          end else begin
            bcnt_n = bcnt + 4'd1;
          end
        end else if (rx_vld) begin
          if (gcnt >= GOOD_C - 8'd1) begin
            bcnt_n = '0;
            gcnt_n = '0;
          end else begin
            gcnt_n = gcnt + 8'd1;
          end
        end
      end
      default: state_n = LOSS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOSS;
      ccnt      <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      prev      <= '0;
      data_out  <= '0;
      data_vld  <= 1'b0;
      comma_det <= 1'b0;
      align_pos <= '0;
      byte_lock <= 1'b0;
    end else begin
      state     <= state_n;
      ccnt      <= ccnt_n;
      bcnt      <= bcnt_n;
      gcnt      <= gcnt_n;
      byte_lock <= (state_n == SYNC);
      data_vld  <= rx_vld;
      if (rx_vld) begin
        prev      <= rx_in;
        data_out  <= aligned;
        align_pos <= new_pos;
        comma_det <= hit && (k_hit == new_pos);
      end
    end
  end

endmodule

// File: tb/tb_comma_align.sv
// Directed bench for comma_align: bit-level stream with known offsets, hand-derived expectations.
module tb_comma_align;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_in = '0;
  logic       rx_vld = 1'b0;
  logic       realign_en = 1'b1;
  logic       err_in = 1'b0;
  logic [9:0] data_out;
  logic       data_vld;
  logic       comma_det;
  logic [3:0] align_pos;
  logic       byte_lock;

  localparam logic [9:0] K285 = 10'h17C;
  localparam logic [9:0] D215 = 10'h155;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic bq[$];

  comma_align #(.LOCK_CNT(4), .ERR_MAX(4), .GOOD_RUN(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_vld(rx_vld),
    .realign_en(realign_en), .err_in(err_in), .data_out(data_out),
    .data_vld(data_vld), .comma_det(comma_det), .align_pos(align_pos),
    .byte_lock(byte_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_w(input logic [9:0] w);
    for (int i = 0; i < 10; i++) bq.push_back(w[i]);
  endtask

  // Alternating 1,0,... filler bits shift the stream without forming a comma.
  task automatic push_pad(input int n);
    for (int i = 0; i < n; i++) bq.push_back((i % 2) == 0);
  endtask

  task automatic push_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      push_w(K285);
      push_w(D215);
    end
  endtask

  task automatic send();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
    rx_in  = w;
    rx_vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_vld = 1'b0;
    err_in = 1'b0;
    rst_n  = 1'b0;
    bq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_vld", 32'(data_vld), 32'h0);
    chk("rst_comma_det", 32'(comma_det), 32'h0);
    chk("rst_align_pos", 32'(align_pos), 32'h0);
    chk("rst_byte_lock", 32'(byte_lock), 32'h0);

    // Offset-3 stream: aligned word j appears after send j+1; commas at even j
    do_reset();
    realign_en = 1'b1;
    push_pad(3);
    push_pairs(8);
    send();
    chk("w0_vld", 32'(data_vld), 32'h1);
    chk("w0_pos", 32'(align_pos), 32'h0);
    for (int i = 1; i <= 7; i++) begin
      send();
      chk($sformatf("lock_data_%0d", i), 32'(data_out), (i % 2) ? 32'(K285) : 32'(D215));
      chk($sformatf("lock_cdet_%0d", i), 32'(comma_det), 32'((i % 2) == 1));
      chk($sformatf("lock_pos_%0d", i), 32'(align_pos), 32'h3);
      chk($sformatf("lock_bl_%0d", i), 32'(byte_lock), 32'(i == 7));
    end

    // Four consecutive decoder errors drop lock on the 4th
    err_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send();
      chk($sformatf("errloss_bl_%0d", i), 32'(byte_lock), 32'(i < 3));
    end
    err_in = 1'b0;

    // 3 errors, 16 good words, 3 errors: good run clears the bad count
    do_reset();
    push_pad(3);
    push_pairs(16);
    for (int i = 0; i < 8; i++) send();
    chk("run_locked", 32'(byte_lock), 32'h1);
    err_in = 1'b1;
    for (int i = 0; i < 3; i++) send();
    err_in = 1'b0;
    for (int i = 0; i < 16; i++) send();
    chk("run_bl_mid", 32'(byte_lock), 32'h1);
    err_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send();
      chk($sformatf("run_bl_%0d", i), 32'(byte_lock), 32'h1);
    end
    err_in = 1'b0;
    send();
    chk("run_bl_end", 32'(byte_lock), 32'h1);
    chk("run_vld_end", 32'(data_vld), 32'h1);

    // Asynchronous reset while locked
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data_out", 32'(data_out), 32'h0);
    chk("arst_data_vld", 32'(data_vld), 32'h0);
    chk("arst_comma_det", 32'(comma_det), 32'h0);
    chk("arst_align_pos", 32'(align_pos), 32'h0);
    chk("arst_byte_lock", 32'(byte_lock), 32'h0);
    rx_vld = 1'b0;
    bq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_w(D215);
    push_w(D215);
    send();
    chk("arst_prev0", 32'(data_out), 32'h0);
    chk("arst_vld1", 32'(data_vld), 32'h1);
    send();
    chk("arst_prev_w", 32'(data_out), 32'(D215));

    // Shift from offset 3 to 7 while in ACQ with two commas counted
    do_reset();
    push_pad(3);
    push_pairs(2);
    push_pad(4);
    push_pairs(6);
    for (int i = 0; i < 4; i++) send();
    chk("shift_pos3", 32'(align_pos), 32'h3);
    send();
    chk("shift_w4_data", 32'(data_out), 32'(D215));
    for (int i = 5; i <= 11; i++) begin
      send();
      chk($sformatf("shift_data_%0d", i), 32'(data_out), (i % 2) ? 32'(K285) : 32'(D215));
      chk($sformatf("shift_pos_%0d", i), 32'(align_pos), 32'h7);
      chk($sformatf("shift_bl_%0d", i), 32'(byte_lock), 32'(i == 11));
    end

    // rx_vld idle for 5 cycles in ACQ with two commas counted
    do_reset();
    push_pad(3);
    push_pairs(6);
    for (int i = 0; i < 4; i++) send();
    rx_vld = 1'b0;
    rx_in  = 10'h2AA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_vld_%0d", i), 32'(data_vld), 32'h0);
      chk($sformatf("idle_pos_%0d", i), 32'(align_pos), 32'h3);
      chk($sformatf("idle_data_%0d", i), 32'(data_out), 32'(K285));
      chk($sformatf("idle_bl_%0d", i), 32'(byte_lock), 32'h0);
    end
    for (int i = 4; i <= 7; i++) begin
      send();
      chk($sformatf("resume_data_%0d", i), 32'(data_out), (i % 2) ? 32'(K285) : 32'(D215));
      chk($sformatf("resume_vld_%0d", i), 32'(data_vld), 32'h1);
      chk($sformatf("resume_bl_%0d", i), 32'(byte_lock), 32'(i == 7));
    end

    // realign_en=0 from reset keeps offset 0 despite offset commas
    realign_en = 1'b0;
    do_reset();
    push_pad(3);
    push_pairs(5);
    for (int i = 0; i < 8; i++) begin
      send();
      chk($sformatf("noal_pos_%0d", i), 32'(align_pos), 32'h0);
      chk($sformatf("noal_cdet_%0d", i), 32'(comma_det), 32'h0);
      chk($sformatf("noal_bl_%0d", i), 32'(byte_lock), 32'h0);
    end
    realign_en = 1'b1;

    rx_vld = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
